irq_controller: RTL and testbench

- Interrupt controller between the eight external `interrupts` pins and the MIPS core's exception logic.
- Synchronises the pins, latches rising edges as pending, applies a software mask and selects the highest-priority enabled request (lowest index).
- Presents that request to the core with an irq/ack handshake.
- Blocks further requests while a handler is in service, until the core signals end-of-interrupt. Edges arriving during a handler are held pending, not lost.

---
 rtl/irq_controller_pkg.sv | 13 +
 rtl/irq_sync_edge.sv | 35 +++
 rtl/irq_controller.sv | 111 +++++++++++
 tb/tb_irq_controller.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_controller_pkg.sv
// Shared definitions for the interrupt controller: FSM state encoding and default sizes.
package irq_controller_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StReq     = 2'b01,
        StService = 2'b10
    } state_e;

    localparam int unsigned NumIrqDefault = 8;
    localparam int unsigned IrqIdW        = 3;

endpackage

// File: rtl/irq_sync_edge.sv
// Per-line multi-flop synchroniser followed by a rising-edge detector.
module irq_sync_edge
    import irq_controller_pkg::*;
#(
    parameter int unsigned NUM_IRQ     = NumIrqDefault,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               ph1,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] din,
    output logic [NUM_IRQ-1:0] rise
);

    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] prev_q;

    always_ff @(posedge ph1) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // prev_q clears in reset, so a line held high across reset release yields one edge.
    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: edge-latched pending bits, software mask, fixed priority
// (index 0 highest) and an irq/ack/eoi handshake with the core.
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int unsigned NUM_IRQ     = NumIrqDefault,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       ph1,
    input  logic                       reset,
    input  logic [NUM_IRQ-1:0]         interrupts,
    input  logic                       mask_we,
    input  logic [NUM_IRQ-1:0]         mask_wdata,
    output logic [NUM_IRQ-1:0]         mask,
    output logic [NUM_IRQ-1:0]         pending,
    output logic                       irq,
    output logic [$clog2(NUM_IRQ)-1:0] irq_id,
    input  logic                       ack,
    input  logic                       eoi,
    output logic                       in_service
);

    localparam int unsigned IdW = $clog2(NUM_IRQ);

    state_e             state_q, state_d;
    logic [IdW-1:0]     id_q, id_d, top_id;
    logic [NUM_IRQ-1:0] rise, pending_q, pending_d, mask_q, req, clr;
    logic               ack_take;

    irq_sync_edge #(
        .NUM_IRQ     (NUM_IRQ),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .ph1   (ph1),
        .reset (reset),
        .din   (interrupts),
        .rise  (rise)
    );

    assign req = pending_q & mask_q;

    // Scan from the top down so the lowest set index wins.
    always_comb begin
        top_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                top_id = IdW'(i);
            end
        end
    end

    always_ff @(posedge ph1) begin
        if (reset) begin
            state_q   <= StIdle;
            id_q      <= '0;
            pending_q <= '0;
            mask_q    <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            pending_q <= pending_d;
            if (mask_we) begin
                mask_q <= mask_wdata;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        ack_take = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d = StReq;
                    id_d    = top_id;
                end
            end
            StReq: begin
                if (ack) begin
                    state_d  = StService;
                    ack_take = 1'b1;
                end else if (!mask_q[id_q]) begin
                    state_d = StIdle;
                end
            end
            StService: begin
                if (eoi) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A fresh edge on the acknowledged line wins over its clear.
    always_comb begin
        clr       = ack_take ? (NUM_IRQ'(1) << id_q) : '0;
        pending_d = rise | (pending_q & ~clr);
    end

    always_comb begin
        irq        = (state_q == StReq);
        in_service = (state_q == StService);
    end

    assign irq_id  = id_q;
    assign pending = pending_q;
    assign mask    = mask_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: stimulus pushes expected snapshots and irq ids into
// queues; independent negedge monitors pop and compare.
module tb_irq_controller;

    logic       ph1 = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] interrupts = '0;
    logic       mask_we = 1'b0;
    logic [7:0] mask_wdata = '0;
    logic [7:0] mask;
    logic [7:0] pending;
    logic       irq;
    logic [2:0] irq_id;
    logic       ack = 1'b0;
    logic       eoi = 1'b0;
    logic       in_service;

    irq_controller #(
        .NUM_IRQ     (8),
        .SYNC_STAGES (2)
    ) dut (
        .ph1        (ph1),
        .reset      (reset),
        .interrupts (interrupts),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .mask       (mask),
        .pending    (pending),
        .irq        (irq),
        .irq_id     (irq_id),
        .ack        (ack),
        .eoi        (eoi),
        .in_service (in_service)
    );

    initial forever #5 ph1 = ~ph1;

    typedef struct {
        string      name;
        logic [7:0] pend;
        logic [7:0] msk;
        logic       irq;
        logic [2:0] id;
        logic       insvc;
    } exp_t;

    exp_t       snapq[$];
    logic [2:0] idq[$];
    logic [7:0] exp_mask = '0;
    logic       irq_prev = 1'b0;
    int         passed = 0;
    int         total = 0;

    // Snapshot monitor: state after the most recent rising edge.
    always @(negedge ph1) begin : snap_mon
        exp_t e;
        if (snapq.size() > 0) begin
            e = snapq.pop_front();
            total++;
            if (pending === e.pend && mask === e.msk && irq === e.irq &&
                irq_id === e.id && in_service === e.insvc) begin
                passed++;
            end else begin
                $display("FAIL %s: got pend=%h mask=%h irq=%b id=%0d insvc=%b, want pend=%h mask=%h irq=%b id=%0d insvc=%b",
                         e.name, pending, mask, irq, irq_id, in_service,
                         e.pend, e.msk, e.irq, e.id, e.insvc);
            end
        end
    end

    // Request monitor: every irq assertion must match the next expected id.
    always @(negedge ph1) begin : irq_mon
        logic [2:0] w;
        if (irq === 1'b1 && irq_prev !== 1'b1) begin
            total++;
            if (idq.size() == 0) begin
                $display("FAIL irq_rise: got unexpected irq id=%0d, want none", irq_id);
            end else begin
                w = idq.pop_front();
                if (irq_id === w) passed++;
                else $display("FAIL irq_rise: got id=%0d, want id=%0d", irq_id, w);
            end
        end
        irq_prev = irq;
    end

    task automatic tick();
        @(posedge ph1);
        #1;
    endtask

    task automatic snap(input string n, input logic [7:0] p, input logic i,
                        input logic [2:0] id, input logic s);
        exp_t e;
        e.name  = n;
        e.pend  = p;
        e.msk   = exp_mask;
        e.irq   = i;
        e.id    = id;
        e.insvc = s;
        snapq.push_back(e);
    endtask

    task automatic wr_mask(input logic [7:0] v);
        mask_we    = 1'b1;
        mask_wdata = v;
        tick();
        mask_we  = 1'b0;
        exp_mask = v;
    endtask

    task automatic ack_eoi();
        ack = 1'b1; tick(); ack = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;
    endtask

    initial begin
        tick(); tick();
        reset = 1'b0;
        snap("reset", 8'h00, 1'b0, 3'd0, 1'b0);

        // Basic: 50 ns pulse on line 1, irq on the 4th edge.
        wr_mask(8'h02);
        idq.push_back(3'd1);
        interrupts = 8'h02;
        tick(); tick(); tick();
        snap("basic_pend", 8'h02, 1'b0, 3'd0, 1'b0);
        tick();
        snap("basic_irq", 8'h02, 1'b1, 3'd1, 1'b0);
        tick();
        interrupts = 8'h00;
        ack = 1'b1; tick(); ack = 1'b0;
        snap("basic_ack", 8'h00, 1'b0, 3'd1, 1'b1);
        eoi = 1'b1; tick(); eoi = 1'b0;
        snap("basic_eoi", 8'h00, 1'b0, 3'd1, 1'b0);
        tick();
        snap("basic_quiet", 8'h00, 1'b0, 3'd1, 1'b0);

        // Priority: lines 0 and 1 together.
        wr_mask(8'hFF);
        idq.push_back(3'd0);
        idq.push_back(3'd1);
        interrupts = 8'h03;
        tick(); tick(); tick(); tick();
        snap("prio_first", 8'h03, 1'b1, 3'd0, 1'b0);
        interrupts = 8'h00;
        ack = 1'b1; tick(); ack = 1'b0;
        snap("prio_ack", 8'h02, 1'b0, 3'd0, 1'b1);
        eoi = 1'b1; tick(); eoi = 1'b0;
        snap("prio_eoi", 8'h02, 1'b0, 3'd0, 1'b0);
        tick();
        snap("prio_second", 8'h02, 1'b1, 3'd1, 1'b0);
        ack_eoi();
        snap("prio_done", 8'h00, 1'b0, 3'd1, 1'b0);

        // Handler isolation: a new edge on line 1 during its own handler.
        idq.push_back(3'd1);
        idq.push_back(3'd1);
        interrupts = 8'h02;
        tick(); tick(); tick(); tick();
        snap("iso_req", 8'h02, 1'b1, 3'd1, 1'b0);
        interrupts = 8'h00;
        ack = 1'b1; tick(); ack = 1'b0;
        snap("iso_svc", 8'h00, 1'b0, 3'd1, 1'b1);
        tick();
        interrupts = 8'h02;
        tick(); tick();
        interrupts = 8'h00;
        tick();
        snap("iso_held", 8'h02, 1'b0, 3'd1, 1'b1);
        tick(); tick();
        snap("iso_wait", 8'h02, 1'b0, 3'd1, 1'b1);
        eoi = 1'b1; tick(); eoi = 1'b0;
        snap("iso_eoi", 8'h02, 1'b0, 3'd1, 1'b0);
        tick();
        snap("iso_rereq", 8'h02, 1'b1, 3'd1, 1'b0);
        ack_eoi();
        snap("iso_done", 8'h00, 1'b0, 3'd1, 1'b0);

        // Masking and withdrawal.
        wr_mask(8'h00);
        interrupts = 8'h08;
        tick(); tick(); tick();
        interrupts = 8'h00;
        snap("mask_off_pend", 8'h08, 1'b0, 3'd1, 1'b0);
        tick(); tick();
        snap("mask_off_wait", 8'h08, 1'b0, 3'd1, 1'b0);
        idq.push_back(3'd3);
        wr_mask(8'h08);
        snap("mask_wr", 8'h08, 1'b0, 3'd1, 1'b0);
        tick();
        snap("mask_on", 8'h08, 1'b1, 3'd3, 1'b0);
        wr_mask(8'h00);
        snap("mask_wd_write", 8'h08, 1'b1, 3'd3, 1'b0);
        tick();
        snap("mask_withdrawn", 8'h08, 1'b0, 3'd3, 1'b0);
        idq.push_back(3'd3);
        wr_mask(8'h08);
        tick();
        snap("mask_rereq", 8'h08, 1'b1, 3'd3, 1'b0);
        ack_eoi();
        snap("mask_done", 8'h00, 1'b0, 3'd3, 1'b0);

        // Collisions: edge with its own ack, ack in SERVICE, eoi in REQ.
        wr_mask(8'h04);
        idq.push_back(3'd2);
        interrupts = 8'h04;
        tick(); tick(); tick(); tick();
        snap("col_req", 8'h04, 1'b1, 3'd2, 1'b0);
        interrupts = 8'h00;
        tick(); tick(); tick();
        interrupts = 8'h04;
        tick(); tick();
        ack = 1'b1; tick(); ack = 1'b0;
        interrupts = 8'h00;
        snap("col_ack_edge", 8'h04, 1'b0, 3'd2, 1'b1);
        ack = 1'b1; tick(); ack = 1'b0;
        snap("col_ack_svc", 8'h04, 1'b0, 3'd2, 1'b1);
        eoi = 1'b1; tick(); eoi = 1'b0;
        snap("col_eoi", 8'h04, 1'b0, 3'd2, 1'b0);
        idq.push_back(3'd2);
        tick();
        snap("col_req2", 8'h04, 1'b1, 3'd2, 1'b0);
        eoi = 1'b1; tick(); eoi = 1'b0;
        snap("col_eoi_req", 8'h04, 1'b1, 3'd2, 1'b0);
        ack_eoi();
        snap("col_done", 8'h00, 1'b0, 3'd2, 1'b0);

        // Reset mid-REQ, then a line held high through reset release.
        wr_mask(8'h01);
        idq.push_back(3'd0);
        interrupts = 8'h05;
        tick(); tick(); tick(); tick();
        snap("rst_req", 8'h05, 1'b1, 3'd0, 1'b0);
        reset = 1'b1;
        interrupts = 8'h08;
        tick();
        exp_mask = 8'h00;
        snap("rst_mid", 8'h00, 1'b0, 3'd0, 1'b0);
        tick();
        idq.push_back(3'd3);
        reset = 1'b0;
        wr_mask(8'h08);
        tick(); tick();
        snap("rst_held_pend", 8'h08, 1'b0, 3'd0, 1'b0);
        tick();
        snap("rst_held_irq", 8'h08, 1'b1, 3'd3, 1'b0);
        ack_eoi();
        snap("rst_done", 8'h00, 1'b0, 3'd3, 1'b0);
        ack = 1'b1; tick(); ack = 1'b0;
        snap("ack_idle", 8'h00, 1'b0, 3'd3, 1'b0);

        tick(); tick();
        total++;
        if (idq.size() == 0 && snapq.size() == 0) passed++;
        else $display("FAIL drain: got ids_left=%0d snaps_left=%0d, want 0 and 0",
                      idq.size(), snapq.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
